// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller: start edge detection, serve hold,
// point scoring, win detection and game-over handling.
// Optional attract mode (demo ball in IDLE) enabled by defining PONG_ATTRACT_EN.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_VAL = 8'(SERVE_FRAMES);

  state_t     state_r, state_nxt;
  logic       start_q;
  logic       start_rise;
  logic [7:0] serve_cnt, serve_cnt_nxt;
  logic [3:0] score_left_nxt, score_right_nxt;
  logic       serve_dir_nxt, winner_nxt;
  logic [3:0] left_inc, right_inc;
`ifdef PONG_ATTRACT_EN
  logic       attract_pulse, attract_pulse_nxt;
`endif

  assign start_rise = start & ~start_q;
  assign left_inc   = score_left + 4'd1;
  assign right_inc  = score_right + 4'd1;
  assign state      = state_r;

  // State, counters, scores and edge-detect register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      start_q     <= 1'b0;
      serve_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
`ifdef PONG_ATTRACT_EN
      attract_pulse <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt;
      start_q     <= start;
      serve_cnt   <= serve_cnt_nxt;
      score_left  <= score_left_nxt;
      score_right <= score_right_nxt;
      serve_dir   <= serve_dir_nxt;
      winner      <= winner_nxt;
`ifdef PONG_ATTRACT_EN
      attract_pulse <= attract_pulse_nxt;
`endif
    end
  end

  // Next-state and next-value logic for all registered state.
  always_comb begin
    state_nxt       = state_r;
    serve_cnt_nxt   = serve_cnt;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    serve_dir_nxt   = serve_dir;
    winner_nxt      = winner;
`ifdef PONG_ATTRACT_EN
    attract_pulse_nxt = 1'b0;
`endif
    unique case (state_r)
      IDLE: begin
        if (start_rise) begin
          score_left_nxt  = '0;
          score_right_nxt = '0;
          serve_cnt_nxt   = '0;
          state_nxt       = SERVE;
        end
`ifdef PONG_ATTRACT_EN
        else if (miss_left || miss_right) begin
          serve_dir_nxt     = ~serve_dir;
          attract_pulse_nxt = 1'b1;
        end
`endif
      end
      SERVE: begin
        if (frame_tick) begin
          serve_cnt_nxt = serve_cnt + 8'd1;
          if (serve_cnt + 8'd1 == SERVE_VAL) state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          serve_dir_nxt = ~serve_dir;
          state_nxt     = POINT;
        end else if (miss_left) begin
          score_right_nxt = right_inc;
          serve_dir_nxt   = 1'b0;
          if (right_inc == WIN_VAL) begin
            winner_nxt = 1'b1;
            state_nxt  = OVER;
          end else begin
            state_nxt = POINT;
          end
        end else if (miss_right) begin
          score_left_nxt = left_inc;
          serve_dir_nxt  = 1'b1;
          if (left_inc == WIN_VAL) begin
            winner_nxt = 1'b0;
            state_nxt  = OVER;
          end else begin
            state_nxt = POINT;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          serve_cnt_nxt = '0;
          state_nxt     = SERVE;
        end
      end
      OVER: begin
        if (start_rise) begin
          score_left_nxt  = '0;
          score_right_nxt = '0;
          serve_cnt_nxt   = '0;
          state_nxt       = SERVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ball control and game-over flag decode straight from the state.
  always_comb begin
    ball_reset = (state_r != PLAY);
    ball_run   = (state_r == PLAY);
    game_over  = (state_r == OVER);
`ifdef PONG_ATTRACT_EN
    if (state_r == IDLE) begin
      ball_reset = attract_pulse;
      ball_run   = ~attract_pulse;
    end
`endif
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl (WIN_SCORE=2, SERVE_FRAMES=3).
module tb_pong_game_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, frame_tick, miss_left, miss_right;
  logic       ball_reset, ball_run, serve_dir, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  pong_game_ctrl #(.WIN_SCORE(2), .SERVE_FRAMES(3)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_reset (ball_reset),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .score_left (score_left),
    .score_right(score_right),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       s, ft, ml, mr;
    logic [2:0] st;
    logic [3:0] sl, sr;
    logic       dir, go, win;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  // Full output check; ball control expectations come from the state.
  task automatic check_all(input int row, input logic [2:0] st, input logic [3:0] sl,
                           input logic [3:0] sr, input logic dir, input logic go,
                           input logic win);
    logic exp_run, exp_rst;
    exp_run = (st == 3'd2);
    exp_rst = (st != 3'd2);
`ifdef PONG_ATTRACT_EN
    if (st == 3'd0) begin
      exp_run = 1'b1;
      exp_rst = 1'b0;
    end
`endif
    check("state", row, 32'(state), 32'(st));
    check("score_left", row, 32'(score_left), 32'(sl));
    check("score_right", row, 32'(score_right), 32'(sr));
    check("serve_dir", row, 32'(serve_dir), 32'(dir));
    check("game_over", row, 32'(game_over), 32'(go));
    check("winner", row, 32'(winner), 32'(win));
    check("ball_run", row, 32'(ball_run), 32'(exp_run));
    check("ball_reset", row, 32'(ball_reset), 32'(exp_rst));
  endtask

  function automatic vec_t mk(input logic s, input logic ft, input logic ml, input logic mr,
                              input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr,
                              input logic dir, input logic go, input logic win);
    vec_t v;
    v.s = s; v.ft = ft; v.ml = ml; v.mr = mr;
    v.st = st; v.sl = sl; v.sr = sr; v.dir = dir; v.go = go; v.win = win;
    return v;
  endfunction

  task automatic step(input logic s, input logic ft, input logic ml, input logic mr);
    start = s; frame_tick = ft; miss_left = ml; miss_right = mr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //        s  ft ml mr   st sl sr dir go win
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // start edge
    tbl.push_back(mk(1, 1, 0, 0,  1, 0, 0, 0, 0, 0)); // held start, tick 1
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0)); // miss ignored in SERVE
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 0)); // tick 2
    tbl.push_back(mk(0, 1, 0, 0,  2, 0, 0, 0, 0, 0)); // tick 3 -> PLAY
    tbl.push_back(mk(0, 1, 1, 0,  3, 0, 1, 0, 0, 0)); // miss_left + tick
    tbl.push_back(mk(0, 0, 0, 0,  3, 0, 1, 0, 0, 0)); // POINT waits
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  3, 1, 1, 1, 0, 0)); // miss_right
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  3, 1, 1, 0, 0, 0)); // double miss toggles dir
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 1, 0, 0, 0)); // start in PLAY ignored
    tbl.push_back(mk(0, 0, 0, 1,  4, 2, 1, 1, 1, 0)); // left reaches WIN_SCORE
    tbl.push_back(mk(0, 0, 1, 0,  4, 2, 1, 1, 1, 0)); // frozen in OVER
    tbl.push_back(mk(0, 1, 0, 0,  4, 2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0, 1, 0, 0)); // restart keeps dir
    tbl.push_back(mk(1, 1, 0, 0,  1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  4, 0, 2, 0, 1, 1)); // right wins
    tbl.push_back(mk(0, 0, 0, 0,  4, 0, 2, 0, 1, 1));

    reset = 1'b1; start = 0; frame_tick = 0; miss_left = 0; miss_right = 0;
    #1;
    check_all(-1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].ft, tbl[i].ml, tbl[i].mr);
      check_all(i, tbl[i].st, tbl[i].sl, tbl[i].sr, tbl[i].dir, tbl[i].go, tbl[i].win);
    end

    // Back to PLAY at 1:0, then asynchronous reset between edges.
    step(1, 0, 0, 0);
    check_all(100, 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check_all(101, 3'd3, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    check_all(102, 3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1);
    frame_tick = 0;
    start = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_all(103, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Start held high through reset counts as an edge at the first clock.
    @(negedge clock);
    reset = 1'b0;
    step(1, 0, 0, 0);
    check_all(104, 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef PONG_ATTRACT_EN
    reset = 1'b1; start = 0;
    #1;
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 0);
    check_all(200, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 0);
    check("attract_ball_reset_pulse", 201, 32'(ball_reset), 32'd1);
    check("attract_ball_run_pulse", 201, 32'(ball_run), 32'd0);
    check("attract_dir", 201, 32'(serve_dir), 32'd1);
    step(0, 0, 0, 0);
    check_all(202, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
